// File: rtl/regfile_write_arbiter.sv
// Owns the RegisterFile write port: clears every register after reset, then
// shares the port between writeback (req0) and the auxiliary path (req1).
module regfile_write_arbiter #(
  parameter int                NUM_REGS     = 16,
  parameter int                ADDR_W       = 4,
  parameter int                DATA_W       = 16,
  parameter int                STARVE_LIMIT = 4,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              WriteReg,
  output logic [ADDR_W-1:0] DstReg,
  output logic [DATA_W-1:0] DstData,
  output logic              init_done
);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int                SC_W       = 4;
  localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_REG   = ADDR_W'(NUM_REGS - 1);

  logic              state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              write_reg_q, write_reg_d;
  logic [ADDR_W-1:0] dst_reg_q, dst_reg_d;
  logic [DATA_W-1:0] dst_data_q, dst_data_d;
  logic              grant0, grant1;

  // A starved req1 outranks req0; otherwise writeback has priority.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_RUN) begin
      if (req1_valid && (starve_cnt_q >= STARVE_MAX)) begin
        grant1 = 1'b1;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    starve_cnt_d = starve_cnt_q;
    write_reg_d  = 1'b0;
    dst_reg_d    = dst_reg_q;
    dst_data_d   = dst_data_q;
    case (state_q)
      ST_INIT: begin
        write_reg_d  = 1'b1;
        dst_reg_d    = init_cnt_q;
        dst_data_d   = INIT_VALUE;
        init_cnt_d   = init_cnt_q + 1'b1;
        starve_cnt_d = '0;
        if (init_cnt_q == LAST_REG) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (grant1) begin
          write_reg_d = 1'b1;
          dst_reg_d   = req1_reg;
          dst_data_d  = req1_data;
        end else if (grant0) begin
          write_reg_d = 1'b1;
          dst_reg_d   = req0_reg;
          dst_data_d  = req0_data;
        end
        // Counts consecutive cycles req1 waited and lost, saturating at the limit.
        if (!req1_valid || grant1) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q < STARVE_MAX) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      starve_cnt_q <= '0;
      write_reg_q  <= 1'b0;
      dst_reg_q    <= '0;
      dst_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      write_reg_q  <= write_reg_d;
      dst_reg_q    <= dst_reg_d;
      dst_data_q   <= dst_data_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign init_done  = (state_q == ST_RUN);
  assign WriteReg   = write_reg_q;
  assign DstReg     = dst_reg_q;
  assign DstData    = dst_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_regfile_write_arbiter;
  localparam int          NUM_REGS     = 16;
  localparam int          ADDR_W       = 4;
  localparam int          DATA_W       = 16;
  localparam int          STARVE_LIMIT = 4;
  localparam logic [15:0] INIT_VALUE   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_reg = '0, req1_reg = '0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, WriteReg, init_done;
  logic [3:0]  DstReg;
  logic [15:0] DstData;

  int checks = 0;
  int errors = 0;
  logic [15:0] obs_rf [NUM_REGS];
  logic [15:0] mem_model [NUM_REGS];

  regfile_write_arbiter #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .INIT_VALUE(INIT_VALUE)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Register file fed by the arbiter's outputs.
  always @(posedge clk) if (WriteReg) obs_rf[DstReg] <= DstData;

  task automatic drive(input logic v0, input logic [3:0] r0, input logic [15:0] d0,
                       input logic v1, input logic [3:0] r1, input logic [15:0] d1);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
  endtask

  // 0 = no grant, 1 = req0, 2 = req1.
  function automatic int model_grant(input logic v0, input logic v1, input int lost);
    if (v1 && lost >= STARVE_LIMIT) return 2;
    if (v0) return 1;
    if (v1) return 2;
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({WriteReg, DstReg, DstData} !== 21'h0) begin
        errors++; $display("FAIL reset_outputs got wr=%b reg=%0d data=%h exp 0/0/0000", WriteReg, DstReg, DstData);
      end
      checks++;
      if ({init_done, req0_ready, req1_ready} !== 3'b000) begin
        errors++; $display("FAIL reset_flags got done/r0/r1=%b%b%b exp 000", init_done, req0_ready, req1_ready);
      end
    end
  endtask

  // Requests stay asserted through init; they must not be accepted.
  task automatic check_init_sequence();
    for (int k = 0; k < NUM_REGS; k++) begin
      @(negedge clk);
      checks++;
      if (WriteReg !== 1'b1 || DstReg !== 4'(k) || DstData !== INIT_VALUE) begin
        errors++; $display("FAIL init_write k=%0d got wr=%b reg=%0d data=%h exp 1/%0d/%h", k, WriteReg, DstReg, DstData, k, INIT_VALUE);
      end
      checks++;
      if (init_done !== (k == NUM_REGS - 1)) begin
        errors++; $display("FAIL init_done k=%0d got %b exp %b", k, init_done, (k == NUM_REGS - 1));
      end
      if (k < NUM_REGS - 1) begin
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          errors++; $display("FAIL init_ready k=%0d got r0=%b r1=%b exp 0/0", k, req0_ready, req1_ready);
        end
      end
    end
  endtask

  task automatic test_init();
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      @(negedge clk);
      checks++;
      if (WriteReg !== 1'b1 || DstReg !== 4'(k) || DstData !== INIT_VALUE) begin
        errors++; $display("FAIL init_write k=%0d got wr=%b reg=%0d data=%h exp 1/%0d/%h", k, WriteReg, DstReg, DstData, k, INIT_VALUE);
      end
      checks++;
      if (init_done !== (k == NUM_REGS - 1)) begin
        errors++; $display("FAIL init_done k=%0d got %b exp %b", k, init_done, (k == NUM_REGS - 1));
      end
      if (k < NUM_REGS - 1) begin
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          errors++; $display("FAIL init_ready k=%0d got r0=%b r1=%b exp 0/0", k, req0_ready, req1_ready);
        end
      end
      if (k == NUM_REGS - 2) drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    end
    $display("init sequence presented registers 0..%0d", NUM_REGS - 1);
    @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) begin
      checks++;
      if (obs_rf[i] !== INIT_VALUE) begin
        errors++; $display("FAIL init_readback reg=%0d got %h exp %h", i, obs_rf[i], INIT_VALUE);
      end
    end
  endtask

  task automatic test_req0_single();
    drive(1'b1, 4'd3, 16'hDEAD, 1'b0, 4'd0, 16'h0);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready got r0=%b r1=%b exp 1/0", req0_ready, req1_ready);
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    checks++;
    if (WriteReg !== 1'b1 || DstReg !== 4'd3 || DstData !== 16'hDEAD) begin
      errors++; $display("FAIL single_write got wr=%b reg=%0d data=%h exp 1/3/dead", WriteReg, DstReg, DstData);
    end
    $display("xfer req0 reg 3 data dead");
    @(negedge clk);
    checks++;
    if (WriteReg !== 1'b0 || DstReg !== 4'd3 || DstData !== 16'hDEAD) begin
      errors++; $display("FAIL single_hold got wr=%b reg=%0d data=%h exp 0/3/dead", WriteReg, DstReg, DstData);
    end
  endtask

  task automatic test_starvation();
    int          r0;
    logic [15:0] d0;
    logic        exp_g1;
    r0 = 1;
    for (int c = 0; c < 6; c++) begin
      d0 = 16'(32'h1111 * r0);
      drive(1'b1, 4'(r0), d0, (c <= 4), 4'd5, 16'hBEEF);
      #1;
      exp_g1 = (c == 4);
      checks++;
      if (req0_ready !== !exp_g1 || req1_ready !== exp_g1) begin
        errors++; $display("FAIL starve_ready c=%0d got r0=%b r1=%b exp %b/%b", c, req0_ready, req1_ready, !exp_g1, exp_g1);
      end
      @(negedge clk);
      checks++;
      if (exp_g1) begin
        if (WriteReg !== 1'b1 || DstReg !== 4'd5 || DstData !== 16'hBEEF) begin
          errors++; $display("FAIL starve_write c=%0d got wr=%b reg=%0d data=%h exp 1/5/beef", c, WriteReg, DstReg, DstData);
        end
        $display("xfer req1 reg 5 data beef");
      end else begin
        if (WriteReg !== 1'b1 || DstReg !== 4'(r0) || DstData !== d0) begin
          errors++; $display("FAIL starve_write c=%0d got wr=%b reg=%0d data=%h exp 1/%0d/%h", c, WriteReg, DstReg, DstData, r0, d0);
        end
        $display("xfer req0 reg %0d data %h", r0, d0);
        r0++;
      end
    end
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
  endtask

  task automatic test_same_addr();
    drive(1'b1, 4'd7, 16'hDEAD, 1'b1, 4'd7, 16'hBEEF);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL same_ready0 got r0=%b r1=%b exp 1/0", req0_ready, req1_ready);
    end
    @(negedge clk);
    checks++;
    if (WriteReg !== 1'b1 || DstReg !== 4'd7 || DstData !== 16'hDEAD) begin
      errors++; $display("FAIL same_write0 got wr=%b reg=%0d data=%h exp 1/7/dead", WriteReg, DstReg, DstData);
    end
    $display("xfer req0 reg 7 data dead");
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'hBEEF);
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL same_ready1 got r0=%b r1=%b exp 0/1", req0_ready, req1_ready);
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    checks++;
    if (WriteReg !== 1'b1 || DstReg !== 4'd7 || DstData !== 16'hBEEF) begin
      errors++; $display("FAIL same_write1 got wr=%b reg=%0d data=%h exp 1/7/beef", WriteReg, DstReg, DstData);
    end
    $display("xfer req1 reg 7 data beef");
    @(negedge clk);
    checks++;
    if (obs_rf[7] !== 16'hBEEF) begin
      errors++; $display("FAIL same_readback got %h exp beef", obs_rf[7]);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (WriteReg !== 1'b0 || DstReg !== 4'd7 || DstData !== 16'hBEEF || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL idle i=%0d got wr=%b reg=%0d data=%h r0=%b r1=%b exp 0/7/beef/0/0", i, WriteReg, DstReg, DstData, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 4'd1, 16'h1111, 1'b1, 4'd9, 16'h9999);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL midrun_pre c=%0d got r0=%b r1=%b exp 1/0", c, req0_ready, req1_ready);
      end
      @(negedge clk);
      $display("xfer req0 reg 1 data 1111");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (WriteReg !== 1'b0 || init_done !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || DstReg !== 4'd0 || DstData !== 16'h0) begin
      errors++; $display("FAIL midrun_reset got wr=%b done=%b r0=%b r1=%b reg=%0d data=%h exp all 0", WriteReg, init_done, req0_ready, req1_ready, DstReg, DstData);
    end
    rst = 1'b0;
    check_init_sequence();
    // A freshly cleared starvation count lets req0 win exactly STARVE_LIMIT times.
    for (int c = 0; c <= STARVE_LIMIT; c++) begin
      #1;
      checks++;
      if (req0_ready !== (c < STARVE_LIMIT) || req1_ready !== (c == STARVE_LIMIT)) begin
        errors++; $display("FAIL midrun_starve c=%0d got r0=%b r1=%b exp %b/%b", c, req0_ready, req1_ready, (c < STARVE_LIMIT), (c == STARVE_LIMIT));
      end
      if (c == STARVE_LIMIT) drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic        p0v, p1v, exp_wr;
    logic [3:0]  p0r, p1r, exp_reg;
    logic [15:0] p0d, p1d, exp_data;
    int          lost, g;
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (NUM_REGS) @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) mem_model[i] = INIT_VALUE;
    exp_wr = 1'b1; exp_reg = 4'(NUM_REGS - 1); exp_data = INIT_VALUE;
    p0v = 1'b0; p1v = 1'b0; p0r = '0; p1r = '0; p0d = '0; p1d = '0;
    lost = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      checks++;
      if (WriteReg !== exp_wr || DstReg !== exp_reg || DstData !== exp_data) begin
        errors++; $display("FAIL rand_write cyc=%0d got wr=%b reg=%0d data=%h exp %b/%0d/%h", cyc, WriteReg, DstReg, DstData, exp_wr, exp_reg, exp_data);
      end
      if (!p0v && $urandom_range(0, 99) < 70) begin
        p0v = 1'b1; p0r = 4'($urandom); p0d = 16'($urandom);
      end
      if (!p1v && $urandom_range(0, 99) < 40) begin
        p1v = 1'b1; p1r = 4'($urandom); p1d = 16'($urandom);
      end
      drive(p0v, p0r, p0d, p1v, p1r, p1d);
      #1;
      g = model_grant(p0v, p1v, lost);
      checks++;
      if (req0_ready !== (g == 1) || req1_ready !== (g == 2)) begin
        errors++; $display("FAIL rand_ready cyc=%0d got r0=%b r1=%b exp %b/%b", cyc, req0_ready, req1_ready, (g == 1), (g == 2));
      end
      lost = (p1v && g != 2) ? lost + 1 : 0;
      if (g == 1) begin
        exp_wr = 1'b1; exp_reg = p0r; exp_data = p0d; p0v = 1'b0;
        mem_model[p0r] = p0d;
        $display("xfer req0 reg %0d data %h", p0r, p0d);
      end else if (g == 2) begin
        exp_wr = 1'b1; exp_reg = p1r; exp_data = p1d; p1v = 1'b0;
        mem_model[p1r] = p1d;
        $display("xfer req1 reg %0d data %h", p1r, p1d);
      end else begin
        exp_wr = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (WriteReg !== exp_wr || DstReg !== exp_reg || DstData !== exp_data) begin
      errors++; $display("FAIL rand_last got wr=%b reg=%0d data=%h exp %b/%0d/%h", WriteReg, DstReg, DstData, exp_wr, exp_reg, exp_data);
    end
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) begin
      checks++;
      if (obs_rf[i] !== mem_model[i]) begin
        errors++; $display("FAIL rand_readback reg=%0d got %h exp %h", i, obs_rf[i], mem_model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_req0_single();
    test_starvation();
    test_same_addr();
    test_idle();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
